// File: rtl/serv_ram_arbiter_if.sv
// serv_ram_arbiter_if
// Bundles the SERV instruction bus, SERV data bus and RAM32 macro port that
// meet at the arbiter. Signal names keep the i_/o_ prefixes as seen from the
// arbiter, so the slave modport reads naturally inside the arbiter.
//   ibus : i_ibus_cyc, i_ibus_adr -> o_ibus_rdt, o_ibus_ack
//   dbus : i_dbus_cyc, i_dbus_adr, i_dbus_we, i_dbus_wdt, i_dbus_sel
//          -> o_dbus_rdt, o_dbus_ack
//   ram  : o_ram_en, o_ram_a, o_ram_we, o_ram_di <- i_ram_do
// Modports: slave = arbiter side, master = SERV core / RAM macro side.
interface serv_ram_arbiter_if #(
    parameter int AW = 5
);
    logic          i_ibus_cyc;
    logic [31:0]   i_ibus_adr;
    logic [31:0]   o_ibus_rdt;
    logic          o_ibus_ack;

    logic          i_dbus_cyc;
    logic [31:0]   i_dbus_adr;
    logic          i_dbus_we;
    logic [31:0]   i_dbus_wdt;
    logic [3:0]    i_dbus_sel;
    logic [31:0]   o_dbus_rdt;
    logic          o_dbus_ack;

    logic          o_ram_en;
    logic [AW-1:0] o_ram_a;
    logic [3:0]    o_ram_we;
    logic [31:0]   o_ram_di;
    logic [31:0]   i_ram_do;

    modport slave (
        input  i_ibus_cyc, i_ibus_adr,
        output o_ibus_rdt, o_ibus_ack,
        input  i_dbus_cyc, i_dbus_adr, i_dbus_we, i_dbus_wdt, i_dbus_sel,
        output o_dbus_rdt, o_dbus_ack,
        output o_ram_en, o_ram_a, o_ram_we, o_ram_di,
        input  i_ram_do
    );

    modport master (
        output i_ibus_cyc, i_ibus_adr,
        input  o_ibus_rdt, o_ibus_ack,
        output i_dbus_cyc, i_dbus_adr, i_dbus_we, i_dbus_wdt, i_dbus_sel,
        input  o_dbus_rdt, o_dbus_ack,
        input  o_ram_en, o_ram_a, o_ram_we, o_ram_di,
        output i_ram_do
    );
endinterface

// File: rtl/serv_ram_arbiter.sv
// serv_ram_arbiter
// Serialises SERV ibus fetches and dbus loads/stores onto one single-port
// RAM32 macro. The winning request drives the RAM combinationally in IDLE;
// reads return data one cycle later, captured into a per-port register and
// acknowledged the cycle after that. Stores are acknowledged one cycle after
// the write edge. Ties are broken round-robin.
// Ports:
//   clk   : sole clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : serv_ram_arbiter_if.slave (ibus, dbus and RAM32 port signals)
module serv_ram_arbiter #(
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 i_rst,
    serv_ram_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, READ, ACK, WACK} state_t;

    state_t        state_reg, state_next;
    logic          grant_reg, grant_next;            // 1 = dbus, 0 = ibus
    logic          last_grant_reg, last_grant_next;  // 1 = dbus, 0 = ibus
    logic          ibus_ack_reg, ibus_ack_next;
    logic          dbus_ack_reg, dbus_ack_next;
    logic [31:0]   ibus_rdt_reg;
    logic [31:0]   dbus_rdt_reg;

    logic          win_dbus;
    logic          ram_en_next;
    logic [AW-1:0] ram_a_next;
    logic [3:0]    ram_we_next;
    logic [31:0]   ram_di_next;

    // dbus wins when alone, or on a tie when ibus had the previous grant.
    assign win_dbus = bus.i_dbus_cyc & (~bus.i_ibus_cyc | ~last_grant_reg);

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        ibus_ack_next   = 1'b0;
        dbus_ack_next   = 1'b0;
        ram_en_next     = 1'b0;
        ram_a_next      = '0;
        ram_we_next     = 4'b0000;
        ram_di_next     = 32'h0;

        case (state_reg)
            IDLE: begin
                if (bus.i_ibus_cyc || bus.i_dbus_cyc) begin
                    grant_next      = win_dbus;
                    last_grant_next = win_dbus;
                    ram_en_next     = 1'b1;
                    ram_a_next      = win_dbus ? bus.i_dbus_adr[AW+1:2]
                                               : bus.i_ibus_adr[AW+1:2];
                    if (win_dbus && bus.i_dbus_we) begin
                        // A store with sel=0 still walks through WACK and is acked.
                        ram_we_next   = bus.i_dbus_sel;
                        ram_di_next   = bus.i_dbus_wdt;
                        dbus_ack_next = 1'b1;
                        state_next    = WACK;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                ibus_ack_next = ~grant_reg;
                dbus_ack_next = grant_reg;
                state_next    = ACK;
            end
            ACK:     state_next = IDLE;
            WACK:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            ibus_ack_reg   <= 1'b0;
            dbus_ack_reg   <= 1'b0;
            ibus_rdt_reg   <= 32'h0;
            dbus_rdt_reg   <= 32'h0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            ibus_ack_reg   <= ibus_ack_next;
            dbus_ack_reg   <= dbus_ack_next;
            // RAM output is valid during READ; capture it for the granted port only.
            if (state_reg == READ) begin
                if (grant_reg) begin
                    dbus_rdt_reg <= bus.i_ram_do;
                end else begin
                    ibus_rdt_reg <= bus.i_ram_do;
                end
            end
        end
    end

    // The RAM port is forced quiet while reset is held, whatever the requests.
    assign bus.o_ram_en   = ram_en_next & ~i_rst;
    assign bus.o_ram_a    = ram_a_next & {AW{~i_rst}};
    assign bus.o_ram_we   = ram_we_next & {4{~i_rst}};
    assign bus.o_ram_di   = ram_di_next & {32{~i_rst}};

    assign bus.o_ibus_ack = ibus_ack_reg;
    assign bus.o_dbus_ack = dbus_ack_reg;
    assign bus.o_ibus_rdt = ibus_rdt_reg;
    assign bus.o_dbus_rdt = dbus_rdt_reg;
endmodule

// File: doc/serv_ram_arbiter.md
# serv_ram_arbiter

Two-master to one-port memory arbiter between the SERV core's instruction bus (ibus) and data bus (dbus) and the single-port RAM32 macro. It replaces the direct tie-off of both SERV buses to the RAM in the Tiny Tapeout top level. It serialises ibus fetches and dbus loads/stores onto the RAM32 port and generates proper per-bus acknowledges. Read data is returned in registers so that SERV sees stable data aligned with its ack.

## Interface
Parameters:
- AW, default 5: RAM word-address width; drives o_ram_a. The request address bits [AW+1:2] are used.

Ports:
- clk  in  1  sole clock, rising edge
- i_rst  in  1  reset; synchronous, active-high; sampled on the rising edge of clk
- i_ibus_cyc  in  1  instruction fetch request, held until ack
- i_ibus_adr  in  32  fetch byte address
- o_ibus_rdt  out  32  fetched word, registered
- o_ibus_ack  out  1  one-cycle fetch acknowledge, registered
- i_dbus_cyc  in  1  data request, held until ack
- i_dbus_adr  in  32  data byte address
- i_dbus_we  in  1  1 = store, 0 = load
- i_dbus_wdt  in  32  store data, already lane-aligned by SERV
- i_dbus_sel  in  4  store byte enables
- o_dbus_rdt  out  32  load word, registered
- o_dbus_ack  out  1  one-cycle data acknowledge, registered
- o_ram_en  out  1  RAM32 EN0
- o_ram_a  out  AW  RAM32 A0
- o_ram_we  out  4  RAM32 WE0 byte write enables
- o_ram_di  out  32  RAM32 Di0
- i_ram_do  in  32  RAM32 Do0; valid the cycle after an enabled read edge

## Operation
- FSM states: IDLE, READ, ACK, WACK. Reset state: IDLE.
- **IDLE, no request**: RAM outputs are 0: o_ram_en=0, o_ram_we=0, o_ram_a=0, o_ram_di=0.
- **IDLE, request present**: pick the winner.
  - Only one cyc high: that bus wins.
  - Both cyc high: round-robin. The bus not granted last wins. The last_grant register resets to "dbus", so ibus wins the first tie.
- **Winner drives the RAM combinationally in IDLE**:
  - o_ram_en=1; o_ram_a = adr[AW+1:2].
  - Winner is ibus, or dbus with we=0: o_ram_we=0, o_ram_di=0. Next state READ.
  - Winner is dbus with we=1: o_ram_we=i_dbus_sel, o_ram_di=i_dbus_wdt. Next state WACK.
  - A store with sel=0 still completes and is acked, with no RAM write.
- **Registered on the grant edge**: grant (ibus/dbus) and last_grant are updated.
- **READ**: RAM outputs are 0. At the end of the cycle, i_ram_do is captured into the granted port's rdt register. Next state ACK.
- **ACK / WACK**: the granted port's ack is 1 for exactly this cycle. Next state IDLE.
- **rdt hold**: each rdt register changes only on a READ→ACK capture for its own port and holds otherwise. o_dbus_rdt is untouched by stores.
- **Address width**: address bits above AW+1 are ignored, so addresses alias modulo 2^(AW+2) bytes. Bits [1:0] are ignored.
- **Master protocol**: a master must drop cyc in the cycle after its ack. A cyc still high in that IDLE cycle is treated as a new request.
- **cyc dropped mid-transaction**: the transaction still completes and the ack is still pulsed.
- **Reset**:
  - Outputs: o_ibus_ack=0, o_dbus_ack=0, o_ibus_rdt=0, o_dbus_rdt=0, all o_ram_* = 0. The RAM is never enabled while i_rst is high.
  - Registers: state IDLE, last_grant=dbus.
  - Reset asserted in READ, ACK or WACK: next state is IDLE, no ack is issued, rdt registers are cleared.

## Timing
- Request seen in IDLE at cycle T: the RAM is addressed in cycle T (same-cycle combinational, no extra register).
- Load or fetch: data captured at the end of T+1; ack and rdt valid in T+2. Latency is 2 cycles.
- Store: written at the end of T; ack in T+1. Latency is 1 cycle.
- Back-to-back:
  - Next grant possible at T+3 after a read and at T+2 after a write.
  - Maximum throughput is one read per 3 cycles and one write per 2 cycles.
- A loser waits at most one transaction under continuous contention (round-robin).
- ack is never high on both ports in the same cycle. ack is never high two cycles in a row on the same port.

## Test plan
- **Reset**: hold i_rst 3 cycles with both cyc high -> both acks 0, both rdt 0, o_ram_en 0 throughout; first grant is in the cycle after i_rst falls.
- **Store then load**:
  - Stimulus: dbus store adr=0x0000_0014, wdt=0xDEADBEEF, sel=4'b1111; then store adr 0x14, sel=4'b0010, wdt=0x0000_5500; then load adr 0x14.
  - Response: o_ram_a=5 with o_ram_we=4'hF in the store cycle; store ack one cycle later; final load ack 2 cycles after grant with o_dbus_rdt=0xDEAD55EF.
- **Contention**: both cyc high from the same cycle, repeated 4 times with SERV-style drop after ack -> grant order ibus, dbus, ibus, dbus; acks never coincide.
- **Aliasing**: store 0x11223344 at adr 0x80, fetch ibus adr 0x00 -> o_ibus_rdt=0x11223344, with o_dbus_rdt unchanged.
- **Reset mid-read**: assert i_rst in READ -> no ack in the following cycle; state back to IDLE; rdt=0; a fresh request after reset completes normally in 2 cycles.
- **Zero-enable store**: dbus we=1, sel=0 -> ack in T+1, o_ram_we=0, and a later read of the same word returns its prior value.
